// File: rtl/gf2m_pentanomial_reducer.sv
// rtl/gf2m_pentanomial_reducer.sv - digit-serial GF(2^283) reducer mod x^283+x^12+x^7+x^5+1
// Optional squarer load path enabled by defining GF2M_REDUCER_SQUARE_EN.
module gf2m_pentanomial_reducer #(
  parameter int M     = 283,
  parameter int DIGIT = 16,
  parameter int K1    = 12,
  parameter int K2    = 7,
  parameter int K3    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef GF2M_REDUCER_SQUARE_EN
  input  logic           sq_mode,
`endif
  input  logic [2*M-1:0] c_in,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   r
);

  localparam int ITER  = (M + DIGIT - 1) / DIGIT;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2*M-1:0]   t_q;
  logic [2*M-1:0]   t_d;
  logic [2*M-1:0]   load_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [M-1:0]     r_q;

  // Bit i belongs to window (2M-1-i)/DIGIT; its fold targets always sit below that window.
  always_comb begin
    t_d = t_q;
    for (int i = M; i < 2*M; i++) begin
      if (cnt_q == CNT_W'((2*M - 1 - i) / DIGIT) && t_q[i]) begin
        t_d[i]          = 1'b0;
        t_d[i - M]      = t_d[i - M] ^ 1'b1;
        t_d[i - M + K3] = t_d[i - M + K3] ^ 1'b1;
        t_d[i - M + K2] = t_d[i - M + K2] ^ 1'b1;
        t_d[i - M + K1] = t_d[i - M + K1] ^ 1'b1;
      end
    end
  end

  always_comb begin
    load_d = c_in;
`ifdef GF2M_REDUCER_SQUARE_EN
    if (sq_mode) begin
      load_d = '0;
      for (int k = 0; k < M; k++) begin
        load_d[2*k] = c_in[k];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            t_q     <= load_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          t_q   <= t_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= DONE;
            r_q     <= t_d[M-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

endmodule

// File: tb/tb_gf2m_pentanomial_reducer.sv
// tb/tb_gf2m_pentanomial_reducer.sv - directed self-checking bench for gf2m_pentanomial_reducer
module tb_gf2m_pentanomial_reducer;

  localparam int M = 283;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sq_mode;
  logic [2*M-1:0] c_in;
  logic           busy;
  logic           done;
  logic [M-1:0]   r;

  int n_checks;
  int n_fail;

  gf2m_pentanomial_reducer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef GF2M_REDUCER_SQUARE_EN
    .sq_mode (sq_mode),
`endif
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .r       (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*M-1:0] mono(input int n);
    logic [2*M-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [M-1:0] p_low();
    logic [M-1:0] v;
    v = '0;
    v[12] = 1'b1; v[7] = 1'b1; v[5] = 1'b1; v[0] = 1'b1;
    return v;
  endfunction

  // Edges after acceptance until done is seen (lat), and cycles busy was high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [2*M-1:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    c_in  = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sq_mode = 1'b0; c_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || r !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%0b done=%0b r=%h required 0 0 0", busy, done, r);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity();
    int lat, bc;
    run_op(mono(0), lat, bc);
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL unity_latency: got %0d required 18", lat); end
    n_checks++;
    if (bc !== 18) begin n_fail++; $display("FAIL unity_busy_cycles: got %0d required 18", bc); end
    n_checks++;
    if (r !== mono(0)) begin n_fail++; $display("FAIL unity_r: got %h required 1", r); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done=%0b required 0", done); end
  endtask

  task automatic test_x283();
    int lat, bc;
    run_op(mono(283), lat, bc);
    n_checks++;
    if (done !== 1'b1 || r !== p_low()) begin
      n_fail++; $display("FAIL x283: done=%0b r=%h required %h", done, r, p_low());
    end
  endtask

  task automatic test_x565();
    int lat, bc;
    logic [M-1:0] e;
    e = '0;
    e[282] = 1'b1; e[23] = 1'b1; e[13] = 1'b1; e[11] = 1'b1;
    e[9] = 1'b1; e[6] = 1'b1; e[4] = 1'b1;
    run_op(mono(565), lat, bc);
    n_checks++;
    if (done !== 1'b1 || r !== e) begin
      n_fail++; $display("FAIL x565: done=%0b r=%h required %h", done, r, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [M-1:0] e282;
    e282 = '0;
    e282[282] = 1'b1;
    run_op(mono(282), lat, bc);
    n_checks++;
    if (r !== e282) begin n_fail++; $display("FAIL b2b_first: r=%h required %h", r, e282); end
    c_in  = mono(283);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_bubble: busy=%0b done=%0b required 1 0", busy, done);
    end
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL b2b_latency: got %0d required 18", lat); end
    n_checks++;
    if (r !== M'(13'h10A1)) begin n_fail++; $display("FAIL b2b_second: r=%h required 10a1", r); end
  endtask

  task automatic test_ignore_start_and_abort();
    int lat;
    bit seen_done;
    @(negedge clk);
    c_in  = mono(283);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c_in  = mono(565);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 5) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL ignore_latency: got %0d required 18", lat); end
    n_checks++;
    if (r !== M'(13'h10A1)) begin n_fail++; $display("FAIL ignore_r: r=%h required 10a1", r); end

    run_op_abort();
  endtask

  task automatic run_op_abort();
    bit seen_done;
    @(negedge clk);
    c_in  = mono(565);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || r !== '0) begin
      n_fail++; $display("FAIL abort_async: busy=%0b done=%0b r=%h required 0 0 0", busy, done, r);
    end
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: activity=%0b required 0", seen_done); end
  endtask

`ifdef GF2M_REDUCER_SQUARE_EN
  task automatic test_square();
    int lat, bc;
    logic [M-1:0] e;
    e = '0;
    e[13] = 1'b1; e[8] = 1'b1; e[6] = 1'b1; e[1] = 1'b1;
    sq_mode = 1'b1;
    run_op(mono(142), lat, bc);
    sq_mode = 1'b0;
    n_checks++;
    if (lat !== 18 || r !== e) begin
      n_fail++; $display("FAIL square: lat=%0d r=%h required 18 %h", lat, r, e);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unity();
    test_x283();
    test_x565();
    test_back_to_back();
    test_ignore_start_and_abort();
`ifdef GF2M_REDUCER_SQUARE_EN
    test_square();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf2m_pentanomial_reducer.md
Name: gf2m_pentanomial_reducer

Overview:
- Digit-serial modular reducer for GF(2^283) over the pentanomial P(x) = x^283 + x^12 + x^7 + x^5 + 1.
- Consumes the unreduced 566-bit carry-less product from the three-way Toom-Cook / schoolbook GF(2) multipliers and returns the 283-bit field element.
- Sits directly downstream of the multiplier in the field-arithmetic datapath.
- Iterative: folds DIGIT high-order bits per cycle under a start/busy/done handshake.

Parameters:
- M, 283: field degree; the result is M bits wide.
- DIGIT, 16: bits folded per cycle; legal range 1..M-K1-1.
- K1, 12: highest middle exponent of P.
- K2, 7: second middle exponent of P.
- K3, 5: lowest middle exponent of P.
- ITER, ceil(M/DIGIT) = 18: derived localparam; number of fold cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- c_in  input  2*M (566)  unreduced product, bit i = coefficient of x^i.
- busy  output  1  high while a reduction is in progress (RUN).
- done  output  1  single-cycle pulse; r is valid in that cycle.
- r  output  M (283)  reduced result; held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, internal work register t=0, iteration counter=0, busy=0, done=0, r=0. Asserting reset mid-RUN aborts the reduction immediately; no done is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE --start--> RUN: on the accepting edge, t<=c_in, counter<=0, busy<=1.
- RUN, one fold per edge, iteration j (0..ITER-1):
  - Window = bits [2M-1-j*DIGIT : max(M, 2M-DIGIT*(j+1))].
  - For each set bit i in the window, XOR x^(i-M)*(x^K1+x^K2+x^K3+1) into t and clear bit i.
  - Fold targets lie at or below i-M+K1 < window low bound, so one pass per window suffices; all window bits fold in parallel.
  - counter<=counter+1.
- RUN -> DONE: on the edge completing iteration ITER-1, r<=t[M-1:0], done<=1, busy<=0.
- Latency: start accepted at edge E0; done=1 and r valid in the cycle after edge E0+18.
- DONE: lasts one cycle. If start is high, it behaves exactly as IDLE accepting start (back-to-back, no bubble). Otherwise -> IDLE with done<=0.
- start while RUN: ignored; no queueing, no error.
- c_in is sampled only on the accepting edge; later changes have no effect.
- r changes only on the RUN->DONE edge or on reset.
- c_in[2M-1] is reduced like any other bit. The multiplier drives it 0, but the reducer must not rely on that.
- Arithmetic is pure XOR (carry-less); no integer adders.

Optional Feature:
- Macro: GF2M_REDUCER_SQUARE_EN.
- Defined:
  - Adds port sq_mode (input, 1).
  - If sq_mode=1 at the accepting edge, t is loaded with the bit-interleaved square of c_in[M-1:0]: t[2k] = c_in[k], odd bits 0, upper c_in bits ignored.
  - The block then acts as a standalone squarer with identical latency.
  - sq_mode=0 behaves as the base block.
- Undefined: no sq_mode port; load is always t<=c_in.

Test Plan:
- rst release, c_in=1, start pulse -> done 18 cycles after the accepting edge, r=1, busy high for exactly 18 cycles.
- c_in = x^283 (only bit 283 set) -> r = x^12+x^7+x^5+1 (bits 12, 7, 5, 0 set).
- c_in = x^565 -> r = x^282+x^23+x^13+x^11+x^9+x^6+x^4.
- c_in = x^282 (already reduced) -> r = x^282. Then hold start high at done -> second reduction with c_in=x^283 starts without a bubble; its done is 18 cycles later and r = 0x10A1.
- start pulsed again at cycle 5 of RUN with different c_in -> ignored; r equals the first operand's result. rst pulled low at cycle 9 of a new run -> busy=0, done=0, r=0 asynchronously, and no done follows.
- [GF2M_REDUCER_SQUARE_EN] sq_mode=1, c_in = x^142 -> r = x^13+x^8+x^6+x (reduction of x^284).
